posit_normalize_prod_es3: RTL

- Downstream consumer of the raw ES3 multiplier output.
- Takes the serialized raw product (sign, scale, 54-bit post-hidden-bit fraction, zero/inf flags) and produces a rounded, encoded 32-bit ES3 posit.
- 3-stage pipeline with valid tracking and a global stall.
- Replaces the normalization/rounding that was removed from the raw multiplier, so raw products can be accumulated or finalized separately.

---
 rtl/posit_normalize_prod_es3.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/posit_normalize_prod_es3.sv
// posit_normalize_prod_es3
//   Turns a raw ES=3 product (sign, signed scale, fraction with the hidden bit
//   already stripped, inf/zero flags) into a rounded 32-bit posit. It is a
//   3-stage pipeline: decode, regime build/shift, then round/encode. A global
//   stall freezes every register.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; drops every in-flight item
//   in_prod    {sgn, scale[SBITS], frac[MBITS], inf, zero}
//   in_valid   in_prod is presented this cycle
//   stall      hold every pipeline register
//   in_ready   ~stall
//   out_posit  encoded posit; holds its last value on bubbles
//   out_valid  out_posit carries a new item
//   out_inf    result is NaR
//   out_zero   result is zero; never set together with out_inf
module posit_normalize_prod_es3 #(
  parameter int NBITS    = 32,
  parameter int ES       = 3,
  parameter int SBITS    = 10,
  parameter int MBITS    = 54,
  parameter int MAXSCALE = 240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SBITS+MBITS+2:0]   in_prod,
  input  logic                     in_valid,
  input  logic                     stall,
  output logic                     in_ready,
  output logic [NBITS-1:0]         out_posit,
  output logic                     out_valid,
  output logic                     out_inf,
  output logic                     out_zero
);
  localparam int STAGES = 3;
  localparam int PW     = SBITS + MBITS + 3;
  localparam int WW     = 2 * NBITS;            // working word for the regime shift
  localparam int BW     = NBITS - 1;            // posit body (everything below the sign)
  localparam int PAD    = WW - 1 - ES - MBITS;  // zero padding below the fraction
  localparam int RW     = $clog2(WW);

  localparam logic signed [SBITS-1:0] SAT_HI  = SBITS'(MAXSCALE);
  localparam logic signed [SBITS-1:0] SAT_LO  = SBITS'(-MAXSCALE);
  localparam logic [SBITS-1:0]        RUN_LIM = SBITS'(NBITS - 1);
  localparam logic [RW-1:0]           RUN_MAX = RW'(NBITS - 1);

  typedef struct packed {
    logic                    sgn;
    logic                    inf;
    logic                    zero;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [SBITS-1:0] k;
    logic [ES-1:0]           e;
    logic [MBITS-1:0]        frac;
  } s1_t;

  typedef struct packed {
    logic                    sgn;
    logic                    inf;
    logic                    zero;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [BW-1:0]           body;
    logic                    guard;
    logic                    sticky;
  } s2_t;

  // Right shift that fills vacated MSBs with 'fill'. Ones-fill builds the
  // positive regime run, zero-fill the negative one.
  function automatic logic [WW-1:0] shift_right(input logic [WW-1:0] x,
                                                input logic [RW-1:0] n,
                                                input logic          fill);
    return fill ? ~((~x) >> n) : (x >> n);
  endfunction

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;

  assign in_ready  = ~stall;
  assign out_valid = vld_pipe[STAGES];

  // ---------------- stage 1: field split and scale decode ----------------
  logic signed [SBITS-1:0] scale;

  always_comb begin
    scale       = in_prod[PW-2 -: SBITS];
    s1_d.sgn    = in_prod[PW-1];
    s1_d.frac   = in_prod[MBITS+1:2];
    s1_d.inf    = in_prod[1];
    s1_d.zero   = in_prod[0];
    s1_d.k      = scale >>> ES;
    s1_d.e      = scale[ES-1:0];
    s1_d.sat_hi = (scale >= SAT_HI);
    s1_d.sat_lo = (scale < SAT_LO);
  end

  // ---------------- stage 2: regime build and body extraction ----------------
  logic                    neg_k;
  logic signed [SBITS-1:0] run_raw;
  logic [RW-1:0]           run;
  logic [WW-1:0]           base;
  logic [WW-1:0]           shifted;
  logic [WW-1:0]           lost_mask;

  always_comb begin
    neg_k   = s1_q.k[SBITS-1];
    // k>=0 needs k+1 leading ones, k<0 needs -k leading zeros; the
    // terminating bit is already sitting at the top of 'base'.
    run_raw = neg_k ? -s1_q.k : s1_q.k + SBITS'(1);
    run     = (run_raw > RUN_LIM) ? RUN_MAX : run_raw[RW-1:0];
    base    = {neg_k, s1_q.e, s1_q.frac, {PAD{1'b0}}};
    shifted = shift_right(base, run, ~neg_k);
    // bits pushed off the bottom of the working word still count as sticky
    lost_mask = (WW'(1) << run) - WW'(1);

    s2_d.sgn    = s1_q.sgn;
    s2_d.inf    = s1_q.inf;
    s2_d.zero   = s1_q.zero;
    s2_d.sat_hi = s1_q.sat_hi;
    s2_d.sat_lo = s1_q.sat_lo;
    s2_d.body   = shifted[WW-1 -: BW];
    s2_d.guard  = shifted[WW-1-BW];
    s2_d.sticky = (|shifted[WW-2-BW:0]) | (|(base & lost_mask));
  end

  // ---------------- stage 3: round, saturate, sign, specials ----------------
  logic             inc;
  logic [BW:0]      sum;
  logic [BW-1:0]    body_r;
  logic [BW-1:0]    mag;
  logic [NBITS-1:0] posit_d;
  logic             inf_d;
  logic             zero_d;

  always_comb begin
    inc = s2_q.guard & (s2_q.sticky | s2_q.body[0]);
    sum = {1'b0, s2_q.body} + {{BW{1'b0}}, inc};

    // A finite product never rounds to zero or to NaR.
    if (sum[BW])                body_r = '1;
    else if (sum[BW-1:0] == '0) body_r = BW'(1);
    else                        body_r = sum[BW-1:0];

    if (s2_q.sat_hi)      body_r = '1;
    else if (s2_q.sat_lo) body_r = BW'(1);

    mag     = s2_q.sgn ? (~body_r + BW'(1)) : body_r;
    posit_d = {s2_q.sgn, mag};
    inf_d   = s2_q.inf;
    zero_d  = s2_q.zero & ~s2_q.inf;

    if (s2_q.inf)       posit_d = {1'b1, {BW{1'b0}}};
    else if (s2_q.zero) posit_d = '0;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_posit <= '0;
      out_inf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid)    s1_q <= s1_d;
      if (vld_pipe[1]) s2_q <= s2_d;
      // outputs hold their last item across bubbles
      if (vld_pipe[2]) begin
        out_posit <= posit_d;
        out_inf   <= inf_d;
        out_zero  <= zero_d;
      end
    end
  end

endmodule
